// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants for the register-file writeback path.
package wb_port_arbiter_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Register-file geometry shared with the register file itself.
    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 1 << REG_ADDR_W;

    localparam int DATA_W_DEF = 32;
    localparam logic [DATA_W_DEF-1:0] ZERO_DATA = '0;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback sources on one side, register-file write port and pending map on the other.
interface wb_port_arbiter_if #(
    parameter int N_SRC  = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [N_SRC-1:0]        src_valid;
    logic [N_SRC*ADDR_W-1:0] src_addr;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic [N_SRC-1:0]        src_ready;
    logic                    we;
    logic [ADDR_W-1:0]       waddr;
    logic [DATA_W-1:0]       wdata;
    logic [(1<<ADDR_W)-1:0]  pending;

    modport master (
        output src_valid, src_addr, src_data,
        input  src_ready, we, waddr, wdata, pending
    );

    modport slave (
        input  src_valid, src_addr, src_data,
        output src_ready, we, waddr, wdata, pending
    );
endinterface

// File: rtl/wb_port_arbiter_rr_age_arbiter.sv
// Round-robin arbiter that holds back younger slots colliding on an address
// with an older occupied slot. Owns the slot age matrix.
module rr_age_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,           // slot occupied
    input  logic [N-1:0]     same_addr [N], // same_addr[a][b]: slots a and b target one register
    input  logic [PTR_W-1:0] rr_ptr,
    input  logic [N-1:0]     load,          // slots loading at the coming edge
    output logic [N-1:0]     grant
);

    // older_reg[i][j]: slot i was loaded before slot j
    logic [N-1:0] older_reg [N];
    logic [N-1:0] blocker   [N];
    logic [N-1:0] elig;
    logic         found;
    int           idx;

    genvar gi, gj;
    generate
        for (gj = 0; gj < N; gj++) begin : g_elig
            for (gi = 0; gi < N; gi++) begin : g_blk
                if (gi == gj) begin : g_self
                    assign blocker[gj][gi] = 1'b0;
                end else begin : g_other
                    assign blocker[gj][gi] = req[gi] & same_addr[gj][gi] & older_reg[gi][gj];
                end
            end
            assign elig[gj] = req[gj] & ~(|blocker[gj]);
        end

        for (gi = 0; gi < N; gi++) begin : g_age
            // A loading slot becomes youngest; same-edge loads rank by index.
            always_ff @(posedge clk) begin
                if (rst) begin
                    older_reg[gi] <= '0;
                end else begin
                    for (int j = 0; j < N; j++) begin
                        if (load[j]) begin
                            older_reg[gi][j] <= (gi != j) && (!load[gi] || (gi < j));
                        end else if (load[gi]) begin
                            older_reg[gi][j] <= 1'b0;
                        end
                    end
                end
            end
        end
    endgenerate

    // First eligible slot scanning upward from rr_ptr, wrapping.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && elig[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Funnels several writeback sources into the single register-file write port
// and publishes which registers still have writes in flight.
import wb_port_arbiter_pkg::*;

module wb_port_arbiter #(
    parameter int N_SRC  = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = REG_ADDR_W
) (
    input logic              clk,
    input logic              rst,
    wb_port_arbiter_if.slave bus
);

    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int N_REG = 1 << ADDR_W;

    logic [N_SRC-1:0]  occ_reg;
    logic [ADDR_W-1:0] addr_reg [N_SRC];
    logic [DATA_W-1:0] data_reg [N_SRC];
    logic [PTR_W-1:0]  rr_ptr_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] waddr_reg;
    logic [DATA_W-1:0] wdata_reg;

    logic [N_SRC-1:0]  grant;
    logic [N_SRC-1:0]  ready;
    logic [N_SRC-1:0]  load;
    logic [ADDR_W-1:0] in_addr  [N_SRC];
    logic [DATA_W-1:0] in_data  [N_SRC];
    logic [N_SRC-1:0]  same_addr [N_SRC];
    logic              any_grant;
    logic [PTR_W-1:0]  grant_idx;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;
    logic [N_REG-1:0]  pending_vec;

    genvar gi, gj;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_src
            assign in_addr[gi] = bus.src_addr[gi*ADDR_W +: ADDR_W];
            assign in_data[gi] = bus.src_data[gi*DATA_W +: DATA_W];
            // Ready bypasses the grant so a draining slot refills without a bubble.
            assign ready[gi]   = rst | ~occ_reg[gi] | grant[gi];
            // Writes to x0 complete the handshake but never occupy the slot.
            assign load[gi]    = bus.src_valid[gi] & ready[gi] & ~rst & (in_addr[gi] != '0);

            for (gj = 0; gj < N_SRC; gj++) begin : g_cmp
                assign same_addr[gi][gj] = (addr_reg[gi] == addr_reg[gj]);
            end

            // Slot holding register: load wins over drain so a grant+reload keeps it full.
            always_ff @(posedge clk) begin
                if (rst) begin
                    occ_reg[gi] <= DISABLE;
                end else if (load[gi]) begin
                    occ_reg[gi]  <= ENABLE;
                    addr_reg[gi] <= in_addr[gi];
                    data_reg[gi] <= in_data[gi];
                end else if (grant[gi]) begin
                    occ_reg[gi] <= DISABLE;
                end
            end
        end
    endgenerate

    rr_age_arbiter #(
        .N     (N_SRC),
        .PTR_W (PTR_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (occ_reg),
        .same_addr (same_addr),
        .rr_ptr    (rr_ptr_reg),
        .load      (load),
        .grant     (grant)
    );

    // Select the granted slot's contents from the one-hot grant.
    always_comb begin
        grant_idx  = '0;
        grant_addr = '0;
        grant_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant[i]) begin
                grant_idx  = PTR_W'(i);
                grant_addr = addr_reg[i];
                grant_data = data_reg[i];
            end
        end
    end

    assign any_grant = |grant;

    // Round-robin pointer moves just past the winner; idle cycles leave it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= '0;
        end else if (any_grant) begin
            rr_ptr_reg <= (grant_idx == PTR_W'(N_SRC-1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    // Registered write port; address/data hold between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_reg    <= DISABLE;
            waddr_reg <= '0;
            wdata_reg <= DATA_W'(ZERO_DATA);
        end else if (any_grant) begin
            we_reg    <= ENABLE;
            waddr_reg <= grant_addr;
            wdata_reg <= grant_data;
        end else begin
            we_reg    <= DISABLE;
        end
    end

    // Pending map covers every slot plus the write currently on the port.
    always_comb begin
        pending_vec = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (occ_reg[i]) pending_vec[addr_reg[i]] = 1'b1;
        end
        if (we_reg) pending_vec[waddr_reg] = 1'b1;
        pending_vec[0] = 1'b0;
    end

    assign bus.src_ready = ready;
    assign bus.we        = we_reg;
    assign bus.waddr     = waddr_reg;
    assign bus.wdata     = wdata_reg;
    assign bus.pending   = pending_vec;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench: accepted writes are queued per destination register; the
// monitor checks every write and the pending map against those queues.
module tb_wb_port_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.N_SRC(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

    wb_port_arbiter #(.N_SRC(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb [NR][$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;
    int   exp_lat  [N];
    int   acc_cnt  [N];
    int   wait_cnt [N];
    int   max_wait [N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic set_src(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.src_valid[i]        = v;
        bus.src_addr[i*AW +: AW] = a;
        bus.src_data[i*DW +: DW] = d;
    endtask

    task automatic idle();
        for (int i = 0; i < N; i++) set_src(i, 1'b0, '0, '0);
    endtask

    task automatic clear_model();
        for (int r = 0; r < NR; r++) sb[r].delete();
    endtask

    function automatic bit model_empty();
        for (int r = 0; r < NR; r++) if (sb[r].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Called at a falling edge with this cycle's inputs applied; records what
    // the coming rising edge accepts, then advances one cycle.
    task automatic tick();
        logic [N-1:0]  rdy;
        logic [AW-1:0] a;
        exp_t          e;
        #1;
        rdy = bus.src_ready;
        for (int i = 0; i < N; i++) begin
            if (bus.src_valid[i]) begin
                if (rdy[i] && !rst) begin
                    acc_cnt[i]++;
                    wait_cnt[i] = 0;
                    a = bus.src_addr[i*AW +: AW];
                    if (a != '0) begin
                        e.data = bus.src_data[i*DW +: DW];
                        e.acc  = cyc;
                        e.lat  = exp_lat[i];
                        sb[a].push_back(e);
                    end
                end else if (!rst) begin
                    wait_cnt[i]++;
                    if (wait_cnt[i] > max_wait[i]) max_wait[i] = wait_cnt[i];
                end
            end
            exp_lat[i] = -1;
        end
        @(negedge clk);
    endtask

    task automatic reset_counters();
        for (int i = 0; i < N; i++) begin
            acc_cnt[i] = 0; wait_cnt[i] = 0; max_wait[i] = 0; exp_lat[i] = -1;
        end
    endtask

    // One reset cycle; model drops everything in flight.
    task automatic do_reset();
        idle();
        rst = 1'b1;
        clear_model();
        tick();
        rst = 1'b0;
        reset_counters();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        idle();
        while (!model_empty() && n < 50) begin
            tick();
            n++;
        end
        repeat (2) tick();
        chk(name, model_empty(), 1'b1);
    endtask

    // Monitor: pending map and every write port transaction, sampled after the edge.
    initial begin
        logic [NR-1:0] ep;
        int            a;
        exp_t          e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                ep = '0;
                for (int r = 1; r < NR; r++) if (sb[r].size() != 0) ep[r] = 1'b1;
                chk("pending", bus.pending, ep);
                if (bus.we) begin
                    a = int'(bus.waddr);
                    $display("write x%0d <= %08h (cycle %0d)", a, bus.wdata, cyc);
                    checks++;
                    if (a == 0 || sb[a].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: got x%0d=%08h expected no write", a, bus.wdata);
                    end else begin
                        e = sb[a].pop_front();
                        if (bus.wdata !== e.data) begin
                            errors++;
                            $display("FAIL wdata x%0d: got %08h expected %08h", a, bus.wdata, e.data);
                        end
                        if (e.lat >= 0) chk("latency", cyc - e.acc, e.lat);
                        else            chk_range("min_latency", cyc - e.acc, 2, 1000);
                    end
                end
            end
        end
    end

    initial begin
        reset_counters();
        idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // Reset state
        chk("reset_we", bus.we, 1'b0);
        chk("reset_waddr", bus.waddr, '0);
        chk("reset_wdata", bus.wdata, '0);
        chk("reset_pending", bus.pending, '0);
        chk("reset_ready", bus.src_ready, 3'b111);

        // Single write, latency 2
        set_src(1, 1'b1, 5'd7, 32'hDEADBEEF);
        exp_lat[1] = 2;
        tick();
        idle();
        chk("single_pend_c1", bus.pending[7], 1'b1);
        chk("single_we_c1", bus.we, 1'b0);
        tick();
        chk("single_we_c2", bus.we, 1'b1);
        chk("single_pend_c2", bus.pending[7], 1'b1);
        tick();
        chk("single_we_c3", bus.we, 1'b0);
        chk("single_pend_c3", bus.pending[7], 1'b0);
        tick();

        // Contention: writes x1, x2, x3 in cycles 2, 3, 4
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_src(i, 1'b1, 5'(i + 1), $urandom);
            exp_lat[i] = 2 + i;
        end
        tick();
        idle();
        repeat (5) tick();
        chk("rr_ptr_end", dut.rr_ptr_reg, '0);
        chk("contention_empty", model_empty(), 1'b1);

        // Fairness with every source streaming
        do_reset();
        for (int c = 0; c < 30; c++) begin
            for (int i = 0; i < N; i++) set_src(i, 1'b1, 5'(20 + i), $urandom);
            tick();
        end
        for (int i = 0; i < N; i++) begin
            chk_range("fair_accepts", acc_cnt[i], 9, 11);
            chk_range("fair_max_wait", max_wait[i], 0, 3);
        end
        drain("fair_drain");

        // Same address: older x5 write lands first
        do_reset();
        set_src(2, 1'b1, 5'd5, 32'h11);
        tick();
        idle();
        set_src(0, 1'b1, 5'd5, 32'h22);
        tick();
        drain("same_addr_drain");

        // Same address loaded on the same edge: lower index is older
        do_reset();
        set_src(2, 1'b1, 5'd6, 32'h33);
        set_src(1, 1'b1, 5'd6, 32'h44);
        tick();
        drain("same_edge_drain");

        // x0 writes are swallowed
        do_reset();
        for (int c = 0; c < 5; c++) begin
            set_src(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
            tick();
            chk("x0_ready", bus.src_ready[0], 1'b1);
        end
        drain("x0_drain");

        // Reset mid-operation
        do_reset();
        for (int i = 0; i < N; i++) set_src(i, 1'b1, 5'(10 + i), $urandom);
        tick();
        idle();
        set_src(0, 1'b1, 5'd9, 32'h99);
        rst = 1'b1;
        clear_model();
        #1;
        chk("rst_ready_in_reset", bus.src_ready, 3'b111);
        tick();
        rst = 1'b0;
        idle();
        chk("rst_we_after", bus.we, 1'b0);
        chk("rst_pending_after", bus.pending, '0);
        chk("rst_ready_after", bus.src_ready, 3'b111);
        set_src(2, 1'b1, 5'd4, 32'hCAFE0004);
        exp_lat[2] = 2;
        tick();
        drain("rst_drain");

        // Random traffic on a small register set to provoke collisions
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, 1) == 1) set_src(i, 1'b1, 5'($urandom_range(0, 7)), $urandom);
                    else                           set_src(i, 1'b0, '0, '0);
                end
                tick();
            end
        end
        drain("random_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
